// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input packet stream multiplexer with a single registered
// output stage and valid/ready handshaking. A channel is granted in IDLE
// (explicit select or round-robin) and held until its last beat transfers.
// CHANNELS must be >= 2 and SEL_W must be >= clog2(CHANNELS).
module stream_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iMODE,
    input  logic [SEL_W-1:0]          iSELECT,
    input  logic [CHANNELS-1:0]       iVALID,
    input  logic [CHANNELS*WIDTH-1:0] iDATA,
    input  logic [CHANNELS-1:0]       iLAST,
    output logic [CHANNELS-1:0]       oREADY,
    output logic                      oVALID,
    output logic [WIDTH-1:0]          oDATA,
    output logic                      oLAST,
    output logic [SEL_W-1:0]          oCHANNEL,
    input  logic                      iREADY,
    output logic                      oERROR
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Channel count widened by one bit so select/candidate compares never overflow.
    localparam logic [SEL_W:0]   CH_LIMIT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] RR_RESET  = SEL_W'(CHANNELS - 1);

    logic [0:0]       state_q,   state_d;
    logic [SEL_W-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic             err_q,     err_d;
    logic             ovalid_q,  ovalid_d;
    logic [WIDTH-1:0] odata_q,   odata_d;
    logic             olast_q,   olast_d;
    logic [SEL_W-1:0] ochan_q,   ochan_d;

    logic             locked_s;
    logic             accept_s;
    logic             load_s;
    logic             sel_oor_s;
    logic             rr_found_s;
    logic [SEL_W-1:0] rr_idx_s;
    logic [SEL_W:0]   rr_cand_s;
    logic [WIDTH-1:0] data_ch_s [CHANNELS];

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_split
            assign data_ch_s[g] = iDATA[g*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can take a new beat when it is empty or draining this cycle.
    assign locked_s  = (state_q == ST_LOCKED);
    assign accept_s  = !ovalid_q || iREADY;
    assign load_s    = locked_s && iVALID[grant_q] && accept_s;
    assign sel_oor_s = ({1'b0, iSELECT} >= CH_LIMIT);

    // Round-robin search: scan from the highest offset down so the lowest
    // offset after rr_ptr (the highest-priority valid channel) is written last.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        rr_cand_s  = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            rr_cand_s = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
            if (rr_cand_s >= CH_LIMIT) begin
                rr_cand_s = rr_cand_s - CH_LIMIT;
            end else begin
                rr_cand_s = rr_cand_s;
            end
            if (iVALID[rr_cand_s[SEL_W-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_cand_s[SEL_W-1:0];
            end else begin
                rr_found_s = rr_found_s;
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Per-channel ready: only the granted channel, only when the output can accept.
    always_comb begin
        oREADY = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (locked_s && (grant_q == SEL_W'(k)) && accept_s) begin
                oREADY[k] = 1'b1;
            end else begin
                oREADY[k] = 1'b0;
            end
        end
    end

    // Arbitration FSM: pick a channel in IDLE, hold it until its last beat transfers.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iMODE == 1'b0) begin
                    if (sel_oor_s) begin
                        err_d = 1'b1;
                    end else if (iVALID[iSELECT]) begin
                        grant_d = iSELECT;
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (rr_found_s) begin
                        grant_d  = rr_idx_s;
                        rr_ptr_d = rr_idx_s;
                        state_d  = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKED: begin
                if (load_s && iLAST[grant_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage next state: load a beat, drain an accepted beat, or hold.
    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        ochan_d  = ochan_q;
        if (load_s) begin
            ovalid_d = 1'b1;
            odata_d  = data_ch_s[grant_q];
            olast_d  = iLAST[grant_q];
            ochan_d  = grant_q;
        end else if (iREADY && ovalid_q) begin
            ovalid_d = 1'b0;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= RR_RESET;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            ochan_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            ochan_q  <= ochan_d;
        end
    end

    assign oVALID   = ovalid_q;
    assign oDATA    = odata_q;
    assign oLAST    = olast_q;
    assign oCHANNEL = ochan_q;
    assign oERROR   = err_q;

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised successor to the team's 2:1 combinational byte mux.
- Selects one of CHANNELS packet streams and forwards it to a single registered output with a valid/ready handshake.
- Holds the selection for a whole packet, through the beat flagged last.
- Sits in the BPF datapath between per-port packet sources and the filter engine input.

Parameters:
- WIDTH, 8: data bits per beat.
- CHANNELS, 4: number of input streams; must be >= 2.
- SEL_W, 2: select and channel-index width; must be >= clog2(CHANNELS).

Ports:
- iCLOCK  in  1: single clock; rising edge.
- inRESET  in  1: asynchronous, active-low reset.
- iMODE  in  1: 0 = explicit select via iSELECT; 1 = round-robin.
- iSELECT  in  SEL_W: requested channel in mode 0.
- iVALID  in  CHANNELS: per-channel beat valid.
- iDATA  in  CHANNELS*WIDTH: channel k occupies [k*WIDTH +: WIDTH].
- iLAST  in  CHANNELS: per-channel last-beat-of-packet flag.
- oREADY  out  CHANNELS: per-channel accept.
- oVALID  out  1: output beat valid.
- oDATA  out  WIDTH: output beat.
- oLAST  out  1: output last flag.
- oCHANNEL  out  SEL_W: source channel of the current output beat.
- iREADY  in  1: downstream accept.
- oERROR  out  1: sticky; set when an out-of-range select is seen.

Behaviour:
- Reset (inRESET=0, async): state=IDLE; oVALID=0; oDATA=0; oLAST=0; oCHANNEL=0; oERROR=0; grant=0; rr_ptr=CHANNELS-1, so channel 0 has first priority. All oREADY=0 during reset.
- Transfer occurs when a valid and its matching ready are both high on a rising edge.
- The output stage is a single register. load = (state==LOCKED) && iVALID[grant] && (!oVALID || iREADY).
- oREADY[k] = (state==LOCKED) && (grant==k) && (!oVALID || iREADY). Combinational; never depends on iVALID.
- On load: oDATA <= iDATA[grant], oLAST <= iLAST[grant], oCHANNEL <= grant, oVALID <= 1.
- If iREADY && oVALID && !load: oVALID <= 0. oDATA, oLAST and oCHANNEL hold their values when oVALID=0.
- FSM, IDLE:
  - iMODE and iSELECT are sampled only in this state.
  - Mode 0: if iSELECT >= CHANNELS, set oERROR and stay IDLE. Otherwise, if iVALID[iSELECT], grant <= iSELECT and go to LOCKED. Otherwise stay IDLE.
  - Mode 1: pick the first k with iVALID[k], scanning from rr_ptr+1 upward with modulo-CHANNELS wrap. Set grant <= k, rr_ptr <= k, go to LOCKED. If no iVALID is set, stay IDLE.
- FSM, LOCKED:
  - On a transfer with iLAST[grant]=1, go to IDLE the next cycle.
  - Otherwise stay LOCKED. Changes to iSELECT and iMODE are ignored.
  - An iVALID[grant] gap is legal; the grant is held.
- Latency: a beat present in IDLE at edge 0 is granted at edge 0, loaded at edge 1, and visible on oDATA after edge 1. Steady-state throughput is one beat per cycle while iVALID[grant] and iREADY are both high.
- Single-beat packets (iLAST on the first beat) cost one IDLE cycle per packet. Minimum packet spacing is 2 cycles.
- Backpressure: while oVALID && !iREADY, oREADY is all zero and the output register is stable.
- Mode 0 in IDLE with the selected channel invalid: remain IDLE, regardless of other channels' valids.
- oERROR clears only on reset.
- Reset mid-packet: the packet is abandoned and the output is dropped immediately. No recovery of partial packets.

Test Plan:
- Mode 0, iSELECT=2, channel 2 sends 3 beats 0x11,0x22,0x33 (last on 0x33), iREADY=1 -> oDATA 0x11,0x22,0x33 on consecutive cycles; oCHANNEL=2; oLAST only on 0x33; oREADY[0,1,3] stay 0.
- Mode 1, all 4 channels continuously valid with 1-beat packets -> grant order 0,1,2,3,0; one output beat every 2 cycles.
- Mode 0, channel 1 sends a 4-beat packet; iREADY held 0 for 3 cycles at beat 2 -> oDATA holds beat 2 stable; oREADY[1]=0; no beat lost or duplicated.
- Mode 0, iSELECT changes 1->3 mid-packet on channel 1 -> channel 1 packet completes, then channel 3 is granted.
- CHANNELS=3, mode 0, iSELECT=3 -> oERROR=1 after the next edge; no oVALID; oERROR stays set until inRESET pulse.
- inRESET asserted at beat 2 of a 5-beat packet -> oVALID=0 and oREADY=0 immediately. After release, a new packet is granted from IDLE with channel 0 priority in mode 1.
